udp_audio_rx: RTL

Receive-side counterpart of the audio-over-UDP transmit path. Parses the GMII receive byte stream from the RGMII/GMII converter. Accepts IPv4/UDP frames addressed to this board, and unpacks the UDP payload into 16-bit audio samples for a downstream sample FIFO and playback logic. Runs entirely in the GMII receive clock domain.

---
 rtl/udp_audio_rx_pkg.sv | 44 ++++
 rtl/udp_audio_rx_sample_packer.sv | 53 +++++
 rtl/udp_audio_rx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/udp_audio_rx_pkg.sv
// audio_rx_pkg
// Shared definitions for the audio-over-UDP receive path: parser state
// encoding, protocol constants, header lengths and a byte-select helper
// used to compare incoming bytes against multi-byte constants.
package audio_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_ETH_HDR  = 3'd2,
    ST_IP_HDR   = 3'd3,
    ST_UDP_HDR  = 3'd4,
    ST_PAYLOAD  = 3'd5,
    ST_DROP     = 3'd6
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
  localparam logic [15:0] IP_HDR_LEN    = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
  localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;

  // Byte idx (0 = most significant, network order) of an nbytes-wide value
  // held in the low bytes of word. Out-of-range idx returns 8'h00.
  function automatic logic [7:0] be_byte(input logic [47:0] word,
                                         input logic [2:0]  nbytes,
                                         input logic [15:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 0; k < 6; k++) begin
      if (k == int'(nbytes) - 1 - int'(idx)) begin
        b = word[8*k +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/udp_audio_rx_sample_packer.sv
// sample_packer
// Pairs consecutive payload bytes into 16-bit samples, first byte high.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   clr_i                restart pairing (next byte is a high byte)
//   byte_i, byte_vld_i   payload byte and its strobe
//   sample_o             last completed sample (registered)
//   sample_vld_o         one-cycle strobe, sample_o updated this cycle
module sample_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_vld_i,
  output logic [15:0] sample_o,
  output logic        sample_vld_o
);

  logic [7:0]  hi_q;
  logic        odd_q;
  logic [15:0] sample_q;
  logic        vld_q;

  // Byte pairing: latch the even byte, emit {hi, odd byte} on the odd one.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_q     <= 8'h00;
      odd_q    <= 1'b0;
      sample_q <= 16'h0000;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (clr_i) begin
        odd_q <= 1'b0;
      end else if (byte_vld_i) begin
        if (odd_q) begin
          sample_q <= {hi_q, byte_i};
          vld_q    <= 1'b1;
          odd_q    <= 1'b0;
        end else begin
          hi_q  <= byte_i;
          odd_q <= 1'b1;
        end
      end else begin
        odd_q <= odd_q;
      end
    end
  end

  assign sample_o     = sample_q;
  assign sample_vld_o = vld_q;

endmodule

// File: rtl/udp_audio_rx.sv
// udp_audio_rx
// Parses the GMII receive stream, accepts IPv4/UDP frames addressed to this
// board and unpacks the UDP payload into 16-bit audio samples.
// Ports:
//   gmii_rx_clk               125 MHz receive clock (only clock)
//   rst_n                     synchronous active-low reset
//   gmii_rx_dv/er, gmii_rxd   GMII receive stream
//   sample_data/sample_valid  audio sample and one-cycle strobe
//   pkt_done                  strobe: good packet payload complete
//   pkt_err                   strobe: accepted packet aborted
//   pkt_cnt                   count of good packets (wraps)
module udp_audio_rx
  import audio_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [15:0] pkt_cnt
);

  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic        fail_q;
  logic        mac_nl_q;    // some MAC byte differed from LOCAL_MAC
  logic        mac_nb_q;    // some MAC byte differed from broadcast
  logic [15:0] len_q;
  logic        pkt_done_q;
  logic        pkt_err_q;
  logic [15:0] pkt_cnt_q;

  logic        hdr_mis_s;
  logic        mac_nl_s;
  logic        mac_nb_s;
  logic        fail_now_s;
  logic        len_bad_s;
  logic [15:0] pay_len_s;
  logic        last_pay_s;
  logic        pk_vld_s;
  logic        pk_clr_s;

  // Header field comparison for the byte currently on gmii_rxd.
  always_comb begin
    hdr_mis_s = 1'b0;
    mac_nl_s  = 1'b0;
    mac_nb_s  = 1'b0;
    case (state_q)
      ST_ETH_HDR: begin
        if (cnt_q < 16'd6) begin
          mac_nl_s = (gmii_rxd != be_byte(LOCAL_MAC, 3'd6, cnt_q));
          mac_nb_s = (gmii_rxd != MAC_BCAST[7:0]);
        end else if (cnt_q == 16'd12) begin
          hdr_mis_s = (gmii_rxd != ETH_TYPE_IPV4[15:8]);
        end else if (cnt_q == 16'd13) begin
          hdr_mis_s = (gmii_rxd != ETH_TYPE_IPV4[7:0]);
        end else begin
          hdr_mis_s = 1'b0;
        end
      end
      ST_IP_HDR: begin
        if (cnt_q == 16'd0) begin
          hdr_mis_s = (gmii_rxd != IP_VER_IHL);
        end else if (cnt_q == 16'd9) begin
          hdr_mis_s = (gmii_rxd != IP_PROTO_UDP);
        end else if (cnt_q >= 16'd16) begin
          hdr_mis_s = (gmii_rxd != be_byte({16'h0000, LOCAL_IP}, 3'd4, cnt_q - 16'd16));
        end else begin
          hdr_mis_s = 1'b0;
        end
      end
      ST_UDP_HDR: begin
        if (cnt_q == 16'd2 || cnt_q == 16'd3) begin
          hdr_mis_s = (gmii_rxd != be_byte({32'h0000_0000, LOCAL_PORT}, 3'd2, cnt_q - 16'd2));
        end else begin
          hdr_mis_s = 1'b0;
        end
      end
      default: begin
        hdr_mis_s = 1'b0;
      end
    endcase
  end

  // The MAC passes if it matched either LOCAL_MAC or broadcast on every byte.
  assign fail_now_s = fail_q | hdr_mis_s | ((mac_nl_q | mac_nl_s) & (mac_nb_q | mac_nb_s));
  assign len_bad_s  = (len_q < UDP_HDR_LEN) | len_q[0];
  assign pay_len_s  = len_q - UDP_HDR_LEN;
  assign last_pay_s = (cnt_q == pay_len_s - 16'd1);
  // An errored byte is never packed, so er on the last byte drops that sample.
  assign pk_vld_s   = (state_q == ST_PAYLOAD) & gmii_rx_dv & ~gmii_rx_er;
  assign pk_clr_s   = (state_q != ST_PAYLOAD);

  // Frame parser: state, byte counter, header checks and packet strobes.
  always_ff @(posedge gmii_rx_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      fail_q     <= 1'b0;
      mac_nl_q   <= 1'b0;
      mac_nb_q   <= 1'b0;
      len_q      <= 16'd0;
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) begin
            state_q <= ST_PREAMBLE;
            cnt_q   <= 16'd0;
          end
        end
        ST_PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
          end else if (gmii_rxd == SFD_BYTE) begin
            state_q  <= ST_ETH_HDR;
            cnt_q    <= 16'd0;
            fail_q   <= 1'b0;
            mac_nl_q <= 1'b0;
            mac_nb_q <= 1'b0;
          end else if (gmii_rxd != PREAMBLE_BYTE) begin
            state_q <= ST_DROP;
            cnt_q   <= 16'd0;
          end
        end
        ST_ETH_HDR, ST_IP_HDR, ST_UDP_HDR, ST_PAYLOAD: begin
          if (!gmii_rx_dv) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            pkt_err_q <= 1'b1;
          end else if (gmii_rx_er) begin
            state_q   <= ST_DROP;
            cnt_q     <= 16'd0;
            pkt_err_q <= 1'b1;
          end else begin
            fail_q   <= fail_now_s;
            mac_nl_q <= mac_nl_q | mac_nl_s;
            mac_nb_q <= mac_nb_q | mac_nb_s;
            case (state_q)
              ST_ETH_HDR: begin
                if (cnt_q == ETH_HDR_LEN - 16'd1) begin
                  state_q <= fail_now_s ? ST_DROP : ST_IP_HDR;
                  cnt_q   <= 16'd0;
                  fail_q  <= 1'b0;
                end else begin
                  cnt_q <= cnt_q + 16'd1;
                end
              end
              ST_IP_HDR: begin
                if (cnt_q == IP_HDR_LEN - 16'd1) begin
                  state_q <= fail_now_s ? ST_DROP : ST_UDP_HDR;
                  cnt_q   <= 16'd0;
                  fail_q  <= 1'b0;
                end else begin
                  cnt_q <= cnt_q + 16'd1;
                end
              end
              ST_UDP_HDR: begin
                if (cnt_q == 16'd4) begin
                  len_q[15:8] <= gmii_rxd;
                end
                if (cnt_q == 16'd5) begin
                  len_q[7:0] <= gmii_rxd;
                end
                if (cnt_q == UDP_HDR_LEN - 16'd1) begin
                  cnt_q  <= 16'd0;
                  fail_q <= 1'b0;
                  if (fail_now_s || len_bad_s) begin
                    state_q <= ST_DROP;
                  end else if (pay_len_s == 16'd0) begin
                    state_q    <= ST_DROP;
                    pkt_done_q <= 1'b1;
                    pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                  end else begin
                    state_q <= ST_PAYLOAD;
                  end
                end else begin
                  cnt_q <= cnt_q + 16'd1;
                end
              end
              ST_PAYLOAD: begin
                if (last_pay_s) begin
                  state_q    <= ST_DROP;
                  cnt_q      <= 16'd0;
                  pkt_done_q <= 1'b1;
                  pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                end else begin
                  cnt_q <= cnt_q + 16'd1;
                end
              end
              default: begin
                state_q <= ST_DROP;
                cnt_q   <= 16'd0;
              end
            endcase
          end
        end
        ST_DROP: begin
          if (!gmii_rx_dv) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 16'd0;
        end
      endcase
    end
  end

  sample_packer u_packer (
    .clk_i        (gmii_rx_clk),
    .rst_ni       (rst_n),
    .clr_i        (pk_clr_s),
    .byte_i       (gmii_rxd),
    .byte_vld_i   (pk_vld_s),
    .sample_o     (sample_data),
    .sample_vld_o (sample_valid)
  );

  assign pkt_done = pkt_done_q;
  assign pkt_err  = pkt_err_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule
